wb_ddr_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one Wishbone slave port (DDR2 controller front end) between NUM_PORTS masters
//  (dbus, ibus, eth0 DMA). Grant locks for the whole cycle, so bursts (cti=010) are never split.

---
 rtl/wb_ddr_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_ddr_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ddr_port_arbiter.sv
// Round-robin Wishbone arbiter: NUM_PORTS masters share one DDR bridge slave port, grant held for a whole cycle.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN (forced release after TIMEOUT stalled strobes).
module wb_ddr_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 1023
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic [NUM_PORTS*AW-1:0]   m_adr_i,
    input  logic [NUM_PORTS*DW-1:0]   m_dat_i,
    input  logic [NUM_PORTS*DW/8-1:0] m_sel_i,
    input  logic [NUM_PORTS-1:0]      m_we_i,
    input  logic [NUM_PORTS-1:0]      m_cyc_i,
    input  logic [NUM_PORTS-1:0]      m_stb_i,
    input  logic [NUM_PORTS*3-1:0]    m_cti_i,
    input  logic [NUM_PORTS*2-1:0]    m_bte_i,
    output logic [NUM_PORTS*DW-1:0]   m_dat_o,
    output logic [NUM_PORTS-1:0]      m_ack_o,
    output logic [NUM_PORTS-1:0]      m_err_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    output logic [NUM_PORTS-1:0]      grant_o,
    output logic                      timeout_o
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = DW / 8;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                 r_state;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [PW-1:0]          r_gidx;
    logic [PW-1:0]          r_rr;

    logic [PW-1:0]          w_pick_idx;
    logic [PW:0]            w_sum;
    logic                   w_busy;
    logic                   w_g_cyc;
    logic                   w_g_stb;
    logic                   w_to;
    logic [PW-1:0]          w_next_rr;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_g_cyc   = w_busy & m_cyc_i[r_gidx];
    assign w_g_stb   = w_busy & m_stb_i[r_gidx];
    assign w_next_rr = (r_gidx == PW'(NUM_PORTS - 1)) ? '0 : r_gidx + PW'(1);

    // Scan offsets from farthest to nearest so the requester closest to r_rr wins.
    always_comb begin
        w_pick_idx = '0;
        w_sum      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_PORTS))
                w_sum = w_sum - (PW+1)'(NUM_PORTS);
            if (m_cyc_i[w_sum[PW-1:0]])
                w_pick_idx = w_sum[PW-1:0];
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_stall;
    logic          r_timeout;

    // Fires during the TIMEOUT-th consecutive stalled strobe cycle.
    assign w_to      = w_g_stb & ~s_ack_i & (r_stall == CW'(TIMEOUT - 1));
    assign timeout_o = r_timeout;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_busy || s_ack_i || w_to)
                r_stall <= '0;
            else if (w_g_stb)
                r_stall <= r_stall + CW'(1);
            if (w_to)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_to      = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|m_cyc_i) begin
                        r_state <= ST_BUSY;
                        r_grant <= NUM_PORTS'(1) << w_pick_idx;
                        r_gidx  <= w_pick_idx;
                    end
                end
                ST_BUSY: begin
                    if (!w_g_cyc || w_to) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_rr    <= w_next_rr;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant_o = r_grant;

    assign s_cyc_o = w_g_cyc & ~w_to;
    assign s_stb_o = w_g_stb & ~w_to;
    assign s_adr_o = w_busy ? m_adr_i[r_gidx*AW +: AW] : '0;
    assign s_dat_o = w_busy ? m_dat_i[r_gidx*DW +: DW] : '0;
    assign s_sel_o = w_busy ? m_sel_i[r_gidx*SW +: SW] : '0;
    assign s_we_o  = w_busy & m_we_i[r_gidx];
    assign s_cti_o = w_busy ? m_cti_i[r_gidx*3 +: 3] : 3'b000;
    assign s_bte_o = w_busy ? m_bte_i[r_gidx*2 +: 2] : 2'b00;

    assign m_ack_o = r_grant & {NUM_PORTS{s_ack_i}};
    assign m_err_o = r_grant & {NUM_PORTS{w_to}};

    always_comb begin
        m_dat_o = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (r_grant[p])
                m_dat_o[p*DW +: DW] = s_dat_i;
    end

endmodule

// File: tb/tb_wb_ddr_port_arbiter.sv
// Directed bench for wb_ddr_port_arbiter: per-cycle vector table plus reset and watchdog sequences.
module tb_wb_ddr_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              wb_clk;
    logic              wb_rst;
    logic [NP*AW-1:0]  m_adr_i;
    logic [NP*DW-1:0]  m_dat_i;
    logic [NP*DW/8-1:0] m_sel_i;
    logic [NP-1:0]     m_we_i;
    logic [NP-1:0]     m_cyc_i;
    logic [NP-1:0]     m_stb_i;
    logic [NP*3-1:0]   m_cti_i;
    logic [NP*2-1:0]   m_bte_i;
    logic [NP*DW-1:0]  m_dat_o;
    logic [NP-1:0]     m_ack_o;
    logic [NP-1:0]     m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW/8-1:0]   s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i;
    logic [NP-1:0]     grant_o;
    logic              timeout_o;

    wb_ddr_port_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    typedef struct {
        bit         rst;
        logic [2:0] cyc;
        logic       ack;
        logic [2:0] cti;
        logic [2:0] g;
        logic       scyc;
        logic [2:0] mack;
    } vec_t;

    vec_t             tbl[$];
    logic [AW-1:0]    adr_c [NP];
    int               n_cmp;
    int               n_err;
    localparam logic [DW-1:0] RD = 32'hDEADBEEF;

    function automatic vec_t mk(bit rst, logic [2:0] cyc, logic ack, logic [2:0] cti,
                                logic [2:0] g, logic scyc, logic [2:0] mack);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.cti = cti;
        v.g = g; v.scyc = scyc; v.mack = mack;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NP*DW-1:0] exp_mdat(input logic [2:0] g);
        logic [NP*DW-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++)
            if (g[p]) r[p*DW +: DW] = RD;
        return r;
    endfunction

    task automatic drive(input logic [2:0] cyc, input logic ack, input logic [2:0] cti);
        m_cyc_i = cyc;
        m_stb_i = cyc;
        s_ack_i = ack;
        m_cti_i = {cti, cti, cti};
    endtask

    initial begin
        logic [AW-1:0] e_adr;
        logic [2:0]    e_cti;
        n_cmp = 0;
        n_err = 0;
        adr_c[0] = 32'h0000_1000;
        adr_c[1] = 32'h0000_0100;
        adr_c[2] = 32'h0000_2000;
        for (int p = 0; p < NP; p++) begin
            m_adr_i[p*AW +: AW] = adr_c[p];
            m_dat_i[p*DW +: DW] = 32'hA000_0000 + p;
        end
        m_sel_i = '1;
        m_we_i  = '0;
        m_bte_i = '0;
        s_dat_i = RD;
        drive(3'b000, 1'b0, 3'b000);
        wb_rst = 1'b1;

        // all three request from reset: 0,1,2,0 with one idle cycle between owners
        tbl.push_back(mk(1, 3'b111, 0, 3'b000, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b111, 1, 3'b000, 3'b001, 1, 3'b001));
        tbl.push_back(mk(0, 3'b110, 0, 3'b000, 3'b001, 0, 3'b000));
        tbl.push_back(mk(0, 3'b110, 0, 3'b000, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b110, 1, 3'b000, 3'b010, 1, 3'b010));
        tbl.push_back(mk(0, 3'b101, 0, 3'b000, 3'b010, 0, 3'b000));
        tbl.push_back(mk(0, 3'b101, 0, 3'b000, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b101, 1, 3'b000, 3'b100, 1, 3'b100));
        tbl.push_back(mk(0, 3'b001, 0, 3'b000, 3'b100, 0, 3'b000));
        tbl.push_back(mk(0, 3'b001, 0, 3'b000, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b001, 1, 3'b000, 3'b001, 1, 3'b001));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b001, 0, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b000));
        // port1 single read, slave acks two cycles after grant
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 3'b010, 1, 3'b000));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 3'b010, 1, 3'b000));
        tbl.push_back(mk(0, 3'b010, 1, 3'b000, 3'b010, 1, 3'b010));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b010, 0, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b000));
        // port0 4-beat incrementing burst while port2 waits
        tbl.push_back(mk(1, 3'b001, 0, 3'b010, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b101, 1, 3'b010, 3'b001, 1, 3'b001));
        tbl.push_back(mk(0, 3'b101, 1, 3'b010, 3'b001, 1, 3'b001));
        tbl.push_back(mk(0, 3'b101, 1, 3'b010, 3'b001, 1, 3'b001));
        tbl.push_back(mk(0, 3'b101, 1, 3'b111, 3'b001, 1, 3'b001));
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 3'b001, 0, 3'b000));
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 3'b000, 0, 3'b000));
        tbl.push_back(mk(0, 3'b100, 1, 3'b000, 3'b100, 1, 3'b100));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b100, 0, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b000));

        #12;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge wb_clk);
            if (tbl[i].rst) begin
                wb_rst = 1'b1;
                #1;
                wb_rst = 1'b0;
            end
            drive(tbl[i].cyc, tbl[i].ack, tbl[i].cti);
            #2;
            e_adr = '0;
            e_cti = 3'b000;
            for (int p = 0; p < NP; p++)
                if (tbl[i].g[p]) begin
                    e_adr = adr_c[p];
                    e_cti = tbl[i].cti;
                end
            chk($sformatf("v%0d grant", i), grant_o, tbl[i].g);
            chk($sformatf("v%0d s_cyc", i), s_cyc_o, tbl[i].scyc);
            chk($sformatf("v%0d s_stb", i), s_stb_o, tbl[i].scyc);
            chk($sformatf("v%0d m_ack", i), m_ack_o, tbl[i].mack);
            chk($sformatf("v%0d m_dat", i), m_dat_o, exp_mdat(tbl[i].g));
            chk($sformatf("v%0d s_adr", i), s_adr_o, e_adr);
            chk($sformatf("v%0d s_cti", i), s_cti_o, e_cti);
            chk($sformatf("v%0d m_err", i), m_err_o, 3'b000);
            chk($sformatf("v%0d timeout", i), timeout_o, 1'b0);
        end

        // asynchronous reset in the middle of an acked beat (rr is 0, only port1 requests)
        @(negedge wb_clk);
        drive(3'b010, 1'b0, 3'b000);
        @(negedge wb_clk);
        s_ack_i = 1'b1;
        #1;
        chk("pre_rst m_ack", m_ack_o, 3'b010);
        chk("pre_rst grant", grant_o, 3'b010);
        wb_rst = 1'b1;
        #1;
        chk("async_rst grant", grant_o, 3'b000);
        chk("async_rst s_cyc", s_cyc_o, 1'b0);
        chk("async_rst m_ack", m_ack_o, 3'b000);
        chk("async_rst m_dat", m_dat_o, '0);
        chk("async_rst s_adr", s_adr_o, 32'h0);
        drive(3'b000, 1'b0, 3'b000);
        #1;
        wb_rst = 1'b0;

        // port2 stalls with no slave ack while port0 waits
        @(negedge wb_clk);
        drive(3'b100, 1'b0, 3'b000);
        @(negedge wb_clk);
        drive(3'b101, 1'b0, 3'b000);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            if (i > 1) @(negedge wb_clk);
            #1;
            if (i < TO) begin
                chk($sformatf("stall%0d m_err", i), m_err_o, 3'b000);
                chk($sformatf("stall%0d s_cyc", i), s_cyc_o, 1'b1);
            end else begin
                chk("to m_err", m_err_o, 3'b100);
                chk("to s_cyc", s_cyc_o, 1'b0);
                chk("to s_stb", s_stb_o, 1'b0);
            end
        end
        @(negedge wb_clk);
        drive(3'b001, 1'b0, 3'b000);
        #1;
        chk("after_to grant", grant_o, 3'b000);
        chk("after_to m_err", m_err_o, 3'b000);
        chk("timeout sticky", timeout_o, 1'b1);
        @(negedge wb_clk);
        #1;
        chk("next owner grant", grant_o, 3'b001);
        chk("timeout held", timeout_o, 1'b1);
`else
        for (int i = 1; i <= 2*TO + 8; i++) begin
            if (i > 1) @(negedge wb_clk);
            #1;
            chk($sformatf("lock%0d grant", i), grant_o, 3'b100);
            chk($sformatf("lock%0d m_err", i), m_err_o, 3'b000);
            chk($sformatf("lock%0d s_cyc", i), s_cyc_o, 1'b1);
            chk($sformatf("lock%0d timeout", i), timeout_o, 1'b0);
        end
`endif
        @(negedge wb_clk);
        drive(3'b000, 1'b0, 3'b000);
        @(negedge wb_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
